vga_timing_controller: RTL
==========================

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 SHALL have parameter RES, default 10: width of every timing parameter output and of cfg_data.
REQ-002 SHALL have ports:
- clock, input, 1: single system clock (50 MHz).
- reset, input, 1: asynchronous, active-low.
- enable, input, 1: run request.
- mode_sel, input, 1: 0 = 640x480 mode, 1 = short sim mode.
- LineEnd, input, 1: line-end level from the hsync module.
- cfg_wr, input, 1: config write strobe.
- cfg_addr, input, 3: register select, 0..7 = hSync, hBack, hActive, hFront, vSync, vBack, vActive, vFront.
- cfg_data, input, RES: write data.
- hSynchPulse/hBackPorch/hActiveVideo/hFrontPorch, output, RES each: active horizontal timing.
- vSynchPulse/vBackPorch/vActiveVideo/vFrontPorch, output, RES each: active vertical timing.
- pixel_en, output, 1: pixel-rate enable.
- sync_rst, output, 1: active-high reset to the sync modules.
- frame_tick, output, 1: one-cycle frame-boundary pulse.
- running, output, 1: high in RUN and DRAIN.
- cfg_err, output, 1: sticky error flag.

Function
REQ-003 SHALL implement FSM OFF -> PRIME -> RUN -> DRAIN -> (PRIME | OFF).
REQ-004 OFF behaviour:
- sync_rst=1, pixel_en=0.
- enable=1 -> load shadow set into active registers, go to PRIME.
REQ-005 PRIME SHALL hold sync_rst=1 for exactly 2 cycles, then enter RUN with sync_rst=0.
REQ-006 In RUN/DRAIN, pixel_en SHALL toggle every clock (divide-by-2), starting at 1 on the first RUN cycle; it SHALL be 0 in OFF/PRIME.
REQ-007 SHALL detect LineEnd rising edges (registered 1-cycle compare) and count lines modulo vtotal.
- vtotal = vSync+vBack+vActive+vFront, computed at RES+2 bits, no truncation.
REQ-008 At line-count wrap, frame_tick SHALL pulse 1 cycle, one clock after the detected LineEnd edge.
REQ-009 A mode_sel change or any accepted cfg write SHALL set pending; in RUN with pending set -> DRAIN.
REQ-010 DRAIN SHALL wait for the next frame_tick, then copy shadow -> active, clear pending, and enter PRIME, giving a new-timing restart of the sync modules.
REQ-011 Active timing outputs SHALL change only on the OFF->PRIME or DRAIN->PRIME transition, never mid-frame.
REQ-012 enable=0 in RUN SHALL enter DRAIN; at the frame boundary go to OFF instead of PRIME; enable re-asserted before the boundary cancels shutdown.
REQ-013 A mode_sel change SHALL reload the whole shadow set from the mode table, overwriting prior cfg writes.
- Mode 0: H 96/48/640/16, V 2/33/480/10.
- Mode 1: H 3/2/6/2, V 3/2/6/2.
REQ-014 A cfg write with cfg_data=0 to an active-video or sync register SHALL be rejected: shadow unchanged, cfg_err=1.
- cfg_err clears only on reset.
REQ-015 cfg_wr and mode_sel change in the same cycle: mode_sel wins and the write is dropped.
REQ-016 A LineEnd edge coincident with the DRAIN->PRIME transition SHALL NOT be counted; the line counter restarts at 0 in PRIME.

Reset
REQ-017 While reset=0, SHALL force:
- state OFF, sync_rst=1, pixel_en=0, frame_tick=0, running=0, cfg_err=0, pending=0, line counter 0.
- shadow and active registers = mode 0 values.
- Mid-frame assertion aborts at once.

Configuration
REQ-018 Macro VGA_CFG_WRITE_EN:
- Defined: cfg_wr/cfg_addr/cfg_data are functional (REQ-014/015 apply).
- Undefined: cfg inputs are ignored, only mode-table values are used, and cfg_err is tied to 0.

Structure
REQ-019 Package vga_timing_pkg SHALL hold mode 0/1 constants, cfg_addr register indices, and the FSM state enumeration.
REQ-020 Mode table SHALL be sub-module vga_mode_rom: combinational, mode_sel in, 8 parameters out.

Verification
REQ-021 Reset release, enable=1, mode 1 -> sync_rst high 2 cycles, then running=1, pixel_en toggling, active V = 3/2/6/2.
REQ-022 Mode 1, 13 LineEnd rising edges -> exactly one frame_tick, one cycle after the 13th edge.
REQ-023 Mode 1 running, write vActive=8 mid-frame -> output stays 6 until frame_tick, then 8 after a 2-cycle sync_rst.
REQ-024 Write cfg_data=0 to addr 4 -> cfg_err=1, vSynchPulse unchanged after the next frame boundary.
REQ-025 enable=0 mid-frame -> running stays 1 until frame_tick, then OFF with sync_rst=1 and pixel_en=0.
REQ-026 reset=0 in DRAIN -> outputs at reset values within the same cycle, timing registers = mode 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode table constants, config register indices and the
// controller state enumeration shared by the VGA timing controller files.
package vga_timing_pkg;

  localparam int NUM_PARAMS = 8;

  // cfg_addr register map
  localparam logic [2:0] ADDR_HSYNC   = 3'd0;
  localparam logic [2:0] ADDR_HBACK   = 3'd1;
  localparam logic [2:0] ADDR_HACTIVE = 3'd2;
  localparam logic [2:0] ADDR_HFRONT  = 3'd3;
  localparam logic [2:0] ADDR_VSYNC   = 3'd4;
  localparam logic [2:0] ADDR_VBACK   = 3'd5;
  localparam logic [2:0] ADDR_VACTIVE = 3'd6;
  localparam logic [2:0] ADDR_VFRONT  = 3'd7;

  // mode 0: 640x480
  localparam int MODE0_HSYNC   = 96;
  localparam int MODE0_HBACK   = 48;
  localparam int MODE0_HACTIVE = 640;
  localparam int MODE0_HFRONT  = 16;
  localparam int MODE0_VSYNC   = 2;
  localparam int MODE0_VBACK   = 33;
  localparam int MODE0_VACTIVE = 480;
  localparam int MODE0_VFRONT  = 10;

  // mode 1: short frames for simulation
  localparam int MODE1_HSYNC   = 3;
  localparam int MODE1_HBACK   = 2;
  localparam int MODE1_HACTIVE = 6;
  localparam int MODE1_HFRONT  = 2;
  localparam int MODE1_VSYNC   = 3;
  localparam int MODE1_VBACK   = 2;
  localparam int MODE1_VACTIVE = 6;
  localparam int MODE1_VFRONT  = 2;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_PRIME,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Timing value for one register of one mode.
  function automatic int mode_param(input logic mode, input logic [2:0] idx);
    int v;
    case (idx)
      ADDR_HSYNC:   v = mode ? MODE1_HSYNC   : MODE0_HSYNC;
      ADDR_HBACK:   v = mode ? MODE1_HBACK   : MODE0_HBACK;
      ADDR_HACTIVE: v = mode ? MODE1_HACTIVE : MODE0_HACTIVE;
      ADDR_HFRONT:  v = mode ? MODE1_HFRONT  : MODE0_HFRONT;
      ADDR_VSYNC:   v = mode ? MODE1_VSYNC   : MODE0_VSYNC;
      ADDR_VBACK:   v = mode ? MODE1_VBACK   : MODE0_VBACK;
      ADDR_VACTIVE: v = mode ? MODE1_VACTIVE : MODE0_VACTIVE;
      default:      v = mode ? MODE1_VFRONT  : MODE0_VFRONT;
    endcase
    return v;
  endfunction

  // Sync and active-video lengths may never be written as zero.
  function automatic logic needs_nonzero(input logic [2:0] idx);
    return (idx == ADDR_HSYNC) || (idx == ADDR_HACTIVE) ||
           (idx == ADDR_VSYNC) || (idx == ADDR_VACTIVE);
  endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// vga_mode_rom: combinational mode table, one RES-wide value per timing
// register, indexed by the cfg_addr register map.
module vga_mode_rom
  import vga_timing_pkg::*;
#(
  parameter int RES = 10
) (
  input  logic                             mode_sel,
  output logic [NUM_PARAMS-1:0][RES-1:0]   params
);

  // table lookup for every register of the selected mode
  always_comb begin
    params = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      params[i] = RES'(mode_param(mode_sel, 3'(i)));
    end
  end

endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: holds a shadow and an active timing set, restarts
// the sync modules (2-cycle sync_rst) whenever a new timing set is applied,
// and only swaps timing at frame boundaries.
// Optional runtime register writes are enabled by defining VGA_CFG_WRITE_EN.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int RES = 10
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic           mode_sel,
  input  logic           LineEnd,
  input  logic           cfg_wr,
  input  logic [2:0]     cfg_addr,
  input  logic [RES-1:0] cfg_data,
  output logic [RES-1:0] hSynchPulse,
  output logic [RES-1:0] hBackPorch,
  output logic [RES-1:0] hActiveVideo,
  output logic [RES-1:0] hFrontPorch,
  output logic [RES-1:0] vSynchPulse,
  output logic [RES-1:0] vBackPorch,
  output logic [RES-1:0] vActiveVideo,
  output logic [RES-1:0] vFrontPorch,
  output logic           pixel_en,
  output logic           sync_rst,
  output logic           frame_tick,
  output logic           running,
  output logic           cfg_err
);

  typedef logic [NUM_PARAMS-1:0][RES-1:0] pset_t;

  state_t         state, state_nxt;
  pset_t          shadow, shadow_nxt, active;
  pset_t          rom_params, reset_params;
  logic           load;
  logic           mode_q, mode_chg;
  logic           wr_ok, wr_rej;
  logic           pending;
  logic           prime_cnt, pix_phase;
  logic           le_q, le_edge, count_en, wrap;
  logic [RES+1:0] vtotal, last_line, line_cnt;

  vga_mode_rom #(.RES(RES)) u_rom (
    .mode_sel (mode_sel),
    .params   (rom_params)
  );

  // Constant mode 0 set used as the reset value of both timing sets.
  vga_mode_rom #(.RES(RES)) u_rom_reset (
    .mode_sel (1'b0),
    .params   (reset_params)
  );

  assign mode_chg = mode_sel != mode_q;

`ifdef VGA_CFG_WRITE_EN
  // A mode change in the same cycle takes precedence and drops the write.
  assign wr_rej = cfg_wr && !mode_chg && needs_nonzero(cfg_addr) && (cfg_data == '0);
  assign wr_ok  = cfg_wr && !mode_chg && !wr_rej;

  // sticky illegal-write flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      cfg_err <= 1'b0;
    else if (wr_rej) cfg_err <= 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_wr, cfg_addr, cfg_data};
  assign wr_rej     = 1'b0;
  assign wr_ok      = 1'b0;
  assign cfg_err    = 1'b0;
`endif

  // next shadow set: mode reload overrides any register write
  always_comb begin
    shadow_nxt = shadow;
    if (mode_chg)   shadow_nxt = rom_params;
    else if (wr_ok) shadow_nxt[cfg_addr] = cfg_data;
  end

  // shadow always tracks writes; active only updates on a restart
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow <= reset_params;
      active <= reset_params;
    end else begin
      shadow <= shadow_nxt;
      if (load) active <= shadow_nxt;
    end
  end

  // pending marks a shadow set that differs from what the sync modules run
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      mode_q <= mode_sel;
      if (load)                   pending <= 1'b0;
      else if (mode_chg || wr_ok) pending <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_OFF;
    else        state <= state_nxt;
  end

  // next-state logic; load copies the (same-cycle updated) shadow to active
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_OFF: begin
        if (enable) begin
          state_nxt = ST_PRIME;
          load      = 1'b1;
        end
      end
      ST_PRIME: begin
        if (prime_cnt) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (pending || !enable) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // re-enable with nothing new to apply simply resumes running
        if (enable && !pending) begin
          state_nxt = ST_RUN;
        end else if (frame_tick) begin
          if (enable) begin
            state_nxt = ST_PRIME;
            load      = 1'b1;
          end else begin
            state_nxt = ST_OFF;
          end
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  assign running  = (state == ST_RUN) || (state == ST_DRAIN);
  assign sync_rst = (state == ST_OFF) || (state == ST_PRIME);
  assign pixel_en = running && pix_phase;

  // prime length counter and divide-by-2 pixel enable (1 on first RUN cycle)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prime_cnt <= 1'b0;
      pix_phase <= 1'b1;
    end else begin
      prime_cnt <= (state == ST_PRIME) ? ~prime_cnt : 1'b0;
      pix_phase <= running ? ~pix_phase : 1'b1;
    end
  end

  assign vtotal    = {2'b00, active[ADDR_VSYNC]}   + {2'b00, active[ADDR_VBACK]} +
                     {2'b00, active[ADDR_VACTIVE]} + {2'b00, active[ADDR_VFRONT]};
  assign last_line = vtotal - (RES+2)'(1);
  assign le_edge   = LineEnd && !le_q;
  // lines only count while running and not leaving the running states, so an
  // edge in the restart cycle is dropped and PRIME starts from line 0
  assign count_en  = running && ((state_nxt == ST_RUN) || (state_nxt == ST_DRAIN));
  assign wrap      = le_edge && (line_cnt == last_line);

  // line counter and frame boundary pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      le_q       <= 1'b0;
      line_cnt   <= '0;
      frame_tick <= 1'b0;
    end else begin
      le_q       <= LineEnd;
      frame_tick <= count_en && wrap;
      if (!count_en)    line_cnt <= '0;
      else if (le_edge) line_cnt <= wrap ? '0 : line_cnt + (RES+2)'(1);
    end
  end

  assign hSynchPulse  = active[ADDR_HSYNC];
  assign hBackPorch   = active[ADDR_HBACK];
  assign hActiveVideo = active[ADDR_HACTIVE];
  assign hFrontPorch  = active[ADDR_HFRONT];
  assign vSynchPulse  = active[ADDR_VSYNC];
  assign vBackPorch   = active[ADDR_VBACK];
  assign vActiveVideo = active[ADDR_VACTIVE];
  assign vFrontPorch  = active[ADDR_VFRONT];

endmodule
